// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between the core
// load/store port and the debug/loader port, with a debug lock/drain FSM.
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    input  logic              dbg_lock,
    output logic              dbg_locked,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [CNT_W-1:0]  core_stall_cnt
);

    localparam logic [1:0] ST_SHARED = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_DBG  = 1'b1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             last_winner;
    logic             rd_pending;
    logic             rd_owner;
    logic [CNT_W-1:0] stall_cnt;
    logic             core_win;
    logic             dbg_win;
    logic             rd_grant;

    // On a tie the requester that did not win last time gets the memory.
    always_comb begin
        core_win = 1'b0;
        dbg_win  = 1'b0;
        case (state)
            ST_SHARED: begin
                if (core_req && dbg_req) begin
                    if (last_winner == OWNER_DBG) begin
                        core_win = 1'b1;
                    end else begin
                        dbg_win = 1'b1;
                    end
                end else begin
                    core_win = core_req;
                    dbg_win  = dbg_req;
                end
            end
            ST_LOCKED: begin
                dbg_win = dbg_req;
            end
            default: begin
                core_win = 1'b0;
                dbg_win  = 1'b0;
            end
        endcase
    end

    assign core_gnt = core_win && !rst;
    assign dbg_gnt  = dbg_win && !rst;
    assign mem_en   = core_gnt || dbg_gnt;
    assign rd_grant = mem_en && !mem_we;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    // DRAIN always lasts one cycle so a read granted just before the lock returns.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SHARED: if (dbg_lock) state_nxt = ST_DRAIN;
            ST_DRAIN:  state_nxt = dbg_lock ? ST_LOCKED : ST_SHARED;
            ST_LOCKED: if (!dbg_lock) state_nxt = ST_SHARED;
            default:   state_nxt = ST_SHARED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_SHARED;
            last_winner <= OWNER_DBG;
            rd_pending  <= 1'b0;
            rd_owner    <= OWNER_CORE;
            stall_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            rd_pending <= rd_grant;
            if (mem_en) begin
                last_winner <= dbg_gnt ? OWNER_DBG : OWNER_CORE;
            end
            if (rd_grant) begin
                rd_owner <= dbg_gnt ? OWNER_DBG : OWNER_CORE;
            end
            if (core_req && !core_gnt && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // A return landing in a reset cycle is dropped.
    assign core_rvalid    = rd_pending && (rd_owner == OWNER_CORE) && !rst;
    assign dbg_rvalid     = rd_pending && (rd_owner == OWNER_DBG) && !rst;
    assign core_rdata     = core_rvalid ? mem_rdata : '0;
    assign dbg_rdata      = dbg_rvalid ? mem_rdata : '0;
    assign dbg_locked     = (state == ST_LOCKED);
    assign core_stall_cnt = stall_cnt;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported 32x32 data memory of the single-cycle datapath between two requesters: the core load/store port and a debug/loader port.
- The debug port is used to preload and inspect memory.
- Arbitration is round-robin with a one-cycle registered read return.
- The debug side can take exclusive ownership through a lock/drain state machine.

Parameters:
- ADDR_W, 5, word address width (32 words).
- DATA_W, 32, data word width.
- CNT_W, 16, width of the core stall counter.

Ports:
- clk  input  1  clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- core_req  input  1  core access request; level, held until granted.
- core_we  input  1  core write enable (1 = write, 0 = read).
- core_addr  input  ADDR_W  core word address.
- core_wdata  input  DATA_W  core write data.
- core_gnt  output  1  core request accepted this cycle.
- core_rvalid  output  1  core read data valid.
- core_rdata  output  DATA_W  core read data.
- dbg_req  input  1  debug access request; level, held until granted.
- dbg_we  input  1  debug write enable.
- dbg_addr  input  ADDR_W  debug word address.
- dbg_wdata  input  DATA_W  debug write data.
- dbg_gnt  output  1  debug request accepted this cycle.
- dbg_rvalid  output  1  debug read data valid.
- dbg_rdata  output  DATA_W  debug read data.
- dbg_lock  input  1  debug requests exclusive ownership; level.
- dbg_locked  output  1  exclusive ownership is in effect.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid the cycle after a read strobe.
- core_stall_cnt  output  CNT_W  saturating count of cycles with core_req=1 and core_gnt=0.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state to SHARED;
  - last_winner to DBG, so the core wins the first tie;
  - rd_pending and rd_owner cleared;
  - core_stall_cnt to 0;
  - dbg_locked, core_rvalid and dbg_rvalid to 0.
- While rst=1, all grants and mem_en are forced to 0.
- Requesters hold req/we/addr/wdata stable until they see gnt=1. gnt is combinational from the requests, state and last_winner. At most one grant per cycle.
- Grant cycle N:
  - mem_en=1; mem_we/addr/wdata are muxed from the winner.
  - last_winner is updated at the N edge.
- Reads: rd_pending and rd_owner are registered at the N edge.
  - In N+1 the owner's rvalid=1 and its rdata=mem_rdata.
  - The other requester's rvalid stays 0. rdata of a non-owner is don't-care (drive 0).
  - Writes never produce rvalid.
- Back-to-back grants are allowed every cycle; the read return of N overlaps the grant of N+1.
- FSM states:
  - SHARED:
    - Grant rule: only one requester asserting -> it wins. Both asserting -> the requester that is not last_winner wins.
    - Transition: dbg_lock=1 -> DRAIN at the next edge. Any grant in that same cycle is still issued.
  - DRAIN:
    - No grants. A read granted in the previous cycle returns here normally.
    - Always exactly one cycle, then -> LOCKED if dbg_lock=1, else -> SHARED.
  - LOCKED:
    - dbg_locked=1. Only dbg requests are granted; core_gnt=0.
    - Transition: dbg_lock=0 -> SHARED at the next edge. dbg_locked drops in that first SHARED cycle, and the core may be granted in it.
- core_stall_cnt increments each cycle with core_req && !core_gnt, including cycles in DRAIN and LOCKED. It holds at 2^CNT_W-1 (saturates).
- Reset mid-read: if rst=1 in cycle N+1, the return is dropped. rvalid=0 in N+1 and afterwards.
- Same address from both ports: accesses are serialized by the grant order. A read granted after a write observes the write.

Test Plan:
- After reset, core read addr 3 with memory model word3=0x2A -> core_gnt=1, mem_en=1, mem_we=0, mem_addr=3 in cycle N; core_rvalid=1, core_rdata=0x2A in N+1; dbg_rvalid=0.
- core_req and dbg_req both held continuously, both reads -> grant order core, dbg, core, dbg; core_stall_cnt=2 after 4 cycles; each rvalid goes to the correct owner one cycle after its grant.
- dbg write addr 31 data 0xDEADBEEF -> dbg_gnt=1, mem_we=1, mem_addr=31, mem_wdata=0xDEADBEEF; no rvalid in the following cycle.
- Core streaming reads, then dbg_lock=1 at cycle N -> core still granted in N; DRAIN in N+1 with no grants and core_rvalid=1; LOCKED from N+2 with dbg_locked=1 and core_gnt=0; drop dbg_lock -> core granted in the first SHARED cycle.
- Core read granted in cycle N, rst=1 in N+1 -> core_rvalid=0 in N+1 and N+2; state SHARED; core_stall_cnt=0.
- Hold LOCKED with core_req=1 for 65540 cycles -> core_stall_cnt=0xFFFF and it does not wrap.
